// File: rtl/mmu_fault_seq_pkg.sv
// Shared definitions for the MMU fault sequencer: state encodings,
// default parameter values and the MMR0 bit positions used by the mmu.
package mmu_fault_seq_pkg;

    localparam logic [7:0] VECTOR_DEF      = 8'o250;
    localparam int         ACK_TIMEOUT_DEF = 16;
    localparam int         CNT_W_DEF       = 16;

    // MMR0 bit positions, kept here so mmu and sequencer agree on them
    localparam int MMR0_ABT_NR   = 15;
    localparam int MMR0_ABT_PLEN = 14;
    localparam int MMR0_ABT_RO   = 13;
    localparam int MMR0_TRAP     = 12;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ABORT  = 3'd1,
        ST_TPEND  = 3'd2,
        ST_VECTOR = 3'd3,
        ST_DFAULT = 3'd4
    } fault_state_t;

endpackage

// File: rtl/mmu_fault_seq_if.sv
// Signals exchanged between the MMU/CPU side (master) and the fault
// sequencer (slave).
interface mmu_fault_seq_if #(
    parameter int CNT_W = 16
);
    logic             access_strobe;
    logic             signal_abort;
    logic             signal_trap;
    logic             cpu_trap;
    logic             instr_done;
    logic             trap_ack;
    logic             bus_inhibit;
    logic             abort_req;
    logic             trap_req;
    logic [7:0]       fault_vector;
    logic             double_fault;
    logic [CNT_W-1:0] fault_count;

    modport master (
        output access_strobe, signal_abort, signal_trap, cpu_trap, instr_done, trap_ack,
        input  bus_inhibit, abort_req, trap_req, fault_vector, double_fault, fault_count
    );

    modport slave (
        input  access_strobe, signal_abort, signal_trap, cpu_trap, instr_done, trap_ack,
        output bus_inhibit, abort_req, trap_req, fault_vector, double_fault, fault_count
    );
endinterface

// File: rtl/mmu_fault_seq.sv
// MMU fault sequencer: turns strobe-qualified MMU abort/trap into CPU
// abort/trap requests through one vector, detects double faults and
// counts accepted faults.
//
//  state     | meaning
//  ----------+------------------------------------------------------
//  ST_IDLE   | no request; traps may be latched pending
//  ST_ABORT  | abort_req high, waiting for trap_ack
//  ST_TPEND  | trap_req high at instruction boundary, waiting for trap_ack
//  ST_VECTOR | CPU servicing the vector; an abort here is a double fault
//  ST_DFAULT | double fault, sticky until reset
module mmu_fault_seq
    import mmu_fault_seq_pkg::*;
#(
    parameter logic [7:0] VECTOR      = VECTOR_DEF,
    parameter int         ACK_TIMEOUT = ACK_TIMEOUT_DEF,
    parameter int         CNT_W       = CNT_W_DEF
) (
    input logic            clk,
    input logic            local_reset,
    mmu_fault_seq_if.slave bus
);

    localparam int               TMR_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

    fault_state_t     state, state_nxt;
    logic             trap_pend, pend_nxt;
    logic             cnt_inc;
    logic [TMR_W-1:0] timer;
    logic [CNT_W-1:0] fault_count_q;
    logic             abort_req_q, trap_req_q, double_fault_q;
    logic             abt, trp, timed_out;

    assign abt       = bus.access_strobe & bus.signal_abort;
    assign trp       = bus.access_strobe & bus.signal_trap & ~bus.signal_abort;
    assign timed_out = (timer == TMR_LAST);

    assign bus.bus_inhibit  = abt;
    assign bus.abort_req    = abort_req_q;
    assign bus.trap_req     = trap_req_q;
    assign bus.double_fault = double_fault_q;
    assign bus.fault_vector = VECTOR;
    assign bus.fault_count  = fault_count_q;

    // State, pending-trap and request flops; requests come straight from flops
    always_ff @(posedge clk or posedge local_reset) begin
        if (local_reset) begin
            state          <= ST_IDLE;
            trap_pend      <= 1'b0;
            abort_req_q    <= 1'b0;
            trap_req_q     <= 1'b0;
            double_fault_q <= 1'b0;
        end else begin
            state          <= state_nxt;
            trap_pend      <= pend_nxt;
            abort_req_q    <= (state_nxt == ST_ABORT);
            trap_req_q     <= (state_nxt == ST_TPEND);
            double_fault_q <= (state_nxt == ST_DFAULT);
        end
    end

    // Next state; VECTOR with cpu_trap dropped behaves exactly like IDLE
    always_comb begin
        state_nxt = state;
        pend_nxt  = trap_pend;
        cnt_inc   = 1'b0;
        unique case (state)
            ST_IDLE, ST_VECTOR: begin
                if (state == ST_VECTOR && bus.cpu_trap) begin
                    if (abt) state_nxt = ST_DFAULT;
                end else if (abt) begin
                    state_nxt = ST_ABORT;
                    pend_nxt  = 1'b0;
                    cnt_inc   = 1'b1;
                end else begin
                    if (state == ST_VECTOR) state_nxt = ST_IDLE;
                    if (trp) begin
                        pend_nxt = 1'b1;
                        cnt_inc  = ~trap_pend;
                    end
                    if (bus.instr_done && (trap_pend || trp)) state_nxt = ST_TPEND;
                end
            end
            ST_ABORT: begin
                if (bus.trap_ack)  state_nxt = ST_VECTOR;
                else if (timed_out) state_nxt = ST_DFAULT;
            end
            ST_TPEND: begin
                if (abt) begin
                    state_nxt = ST_ABORT;
                    pend_nxt  = 1'b0;
                    cnt_inc   = 1'b1;
                end else if (bus.trap_ack) begin
                    state_nxt = ST_VECTOR;
                    pend_nxt  = 1'b0;
                end else if (timed_out) begin
                    state_nxt = ST_DFAULT;
                end
            end
            ST_DFAULT: state_nxt = ST_DFAULT;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Ack timer: restarts on every state change, runs only while a request is up
    always_ff @(posedge clk or posedge local_reset) begin
        if (local_reset)
            timer <= '0;
        else if (state_nxt != state)
            timer <= '0;
        else if (state == ST_ABORT || state == ST_TPEND)
            timer <= timer + TMR_W'(1);
        else
            timer <= '0;
    end

    // Saturating count of accepted aborts and traps
    always_ff @(posedge clk or posedge local_reset) begin
        if (local_reset)
            fault_count_q <= '0;
        else if (cnt_inc && (fault_count_q != '1))
            fault_count_q <= fault_count_q + CNT_W'(1);
    end

endmodule

// File: tb/tb_mmu_fault_seq.sv
// Scoreboard bench for mmu_fault_seq: stimulus pushes the expected
// request-vector change (with cycle and count); a monitor pops on every
// change of {abort_req, trap_req, double_fault}.
module tb_mmu_fault_seq;
    import mmu_fault_seq_pkg::*;

    localparam int CW = 8;   // narrow counter so saturation is reached quickly

    typedef struct {
        logic [2:0]    reqs;
        logic [CW-1:0] cnt;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic local_reset;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t exp_q[$];

    mmu_fault_seq_if #(.CNT_W(CW)) bus ();

    mmu_fault_seq #(.VECTOR(8'o250), .ACK_TIMEOUT(16), .CNT_W(CW)) dut (
        .clk         (clk),
        .local_reset (local_reset),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_in(input logic stb, input logic ab, input logic tr,
                          input logic ct, input logic idn, input logic ack);
        bus.access_strobe = stb;
        bus.signal_abort  = ab;
        bus.signal_trap   = tr;
        bus.cpu_trap      = ct;
        bus.instr_done    = idn;
        bus.trap_ack      = ack;
    endtask

    task automatic expect_evt(input logic ab, input logic tr, input logic df,
                              input int cnt, input int d);
        exp_t e;
        e.reqs = {ab, tr, df};
        e.cnt  = CW'(cnt);
        e.cyc  = cyc + d;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic apply_reset(input logic reqs_up);
        set_in(0, 0, 0, 0, 0, 0);
        if (reqs_up) expect_evt(0, 0, 0, 0, 1);
        local_reset = 1'b1;
        step(2);
        local_reset = 1'b0;
        step(1);
        chk("rst_abort_req", 32'(bus.abort_req), 0);
        chk("rst_trap_req", 32'(bus.trap_req), 0);
        chk("rst_double_fault", 32'(bus.double_fault), 0);
        chk("rst_fault_count", 32'(bus.fault_count), 0);
    endtask

    // Monitor: sample after each active edge, compare on every request change
    initial begin : monitor
        logic [2:0] prev, cur;
        exp_t e;
        prev = 3'b000;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            cur = {bus.abort_req, bus.trap_req, bus.double_fault};
            if (cur !== prev) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_evt cyc=%0d reqs=%b cnt=%0d required no change",
                             cyc, cur, bus.fault_count);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e.reqs || bus.fault_count !== e.cnt || cyc != e.cyc) begin
                        bad++;
                        $display("FAIL evt reqs=%b cnt=%0d cyc=%0d required reqs=%b cnt=%0d cyc=%0d",
                                 cur, bus.fault_count, cyc, e.reqs, e.cnt, e.cyc);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        set_in(0, 0, 0, 0, 0, 0);
        local_reset = 1'b1;
        step(2);
        local_reset = 1'b0;
        step(1);
        chk("init_abort_req", 32'(bus.abort_req), 0);
        chk("init_trap_req", 32'(bus.trap_req), 0);
        chk("init_double_fault", 32'(bus.double_fault), 0);
        chk("init_fault_count", 32'(bus.fault_count), 0);
        chk("fault_vector", 32'(bus.fault_vector), 32'o250);

        // 1: abort in IDLE, ack into VECTOR, cpu_trap drop back to IDLE
        set_in(1, 1, 0, 0, 0, 0);
        #1 chk("bus_inhibit_abt", 32'(bus.bus_inhibit), 1);
        expect_evt(1, 0, 0, 1, 1);
        step(1);
        set_in(0, 0, 0, 0, 0, 0); step(2);
        set_in(0, 0, 0, 1, 0, 1); expect_evt(0, 0, 0, 1, 1); step(1);
        set_in(0, 0, 0, 1, 0, 0); step(2);
        set_in(0, 0, 0, 0, 0, 0); step(1);

        // 2: trap (repeated, counted once) deferred to instruction end
        set_in(1, 0, 1, 0, 0, 0); step(2);
        set_in(0, 0, 0, 0, 0, 0); step(2);
        set_in(0, 0, 0, 0, 1, 0); expect_evt(0, 1, 0, 2, 1); step(1);
        set_in(0, 0, 0, 0, 0, 0); step(3);
        set_in(0, 0, 0, 1, 0, 1); expect_evt(0, 0, 0, 2, 1); step(1);
        set_in(0, 0, 0, 1, 0, 0); step(1);
        set_in(0, 0, 0, 0, 0, 0); step(1);

        // 3: pending trap overtaken by abort; the pending trap is dropped
        set_in(1, 0, 1, 0, 0, 0); step(1);
        set_in(0, 0, 0, 0, 0, 0); step(1);
        set_in(1, 1, 1, 0, 0, 0); expect_evt(1, 0, 0, 4, 1); step(1);
        set_in(0, 0, 0, 0, 0, 0); step(1);
        set_in(0, 0, 0, 1, 0, 1); expect_evt(0, 0, 0, 4, 1); step(1);
        set_in(0, 0, 0, 1, 0, 0); step(1);
        set_in(0, 0, 0, 0, 1, 0); step(2);
        set_in(0, 0, 0, 0, 0, 0); step(1);

        // TPEND: abort beats a same-clk ack; VECTOR with cpu_trap low takes the abort
        set_in(1, 0, 1, 0, 1, 0); expect_evt(0, 1, 0, 5, 1); step(1);
        set_in(0, 0, 0, 0, 0, 0); step(2);
        set_in(1, 1, 0, 0, 0, 1); expect_evt(1, 0, 0, 6, 1); step(1);
        set_in(0, 0, 0, 0, 0, 0); step(1);
        set_in(0, 0, 0, 1, 0, 1); expect_evt(0, 0, 0, 6, 1); step(1);
        set_in(1, 0, 1, 1, 0, 0); step(1);
        set_in(0, 1, 0, 1, 0, 0);
        #1 chk("bus_inhibit_nostrobe", 32'(bus.bus_inhibit), 0);
        step(1);
        set_in(1, 1, 0, 0, 0, 0); expect_evt(1, 0, 0, 7, 1); step(1);
        set_in(0, 0, 0, 0, 0, 0); step(1);
        set_in(0, 0, 0, 1, 0, 1); expect_evt(0, 0, 0, 7, 1); step(1);
        set_in(0, 0, 0, 1, 0, 0); step(1);

        // 4: abort while servicing the vector -> sticky double fault
        set_in(1, 1, 0, 1, 0, 0);
        #1 chk("bus_inhibit_vec", 32'(bus.bus_inhibit), 1);
        expect_evt(0, 0, 1, 7, 1);
        step(1);
        set_in(1, 1, 1, 1, 1, 1); step(3);
        set_in(0, 0, 0, 0, 0, 0); step(2);
        chk("dfault_sticky", 32'(bus.double_fault), 1);
        chk("dfault_no_count", 32'(bus.fault_count), 7);
        apply_reset(1'b1);

        // 5: no ack -> double fault 16 clks after the request rises
        set_in(1, 1, 0, 0, 0, 0); expect_evt(1, 0, 0, 1, 1); step(1);
        set_in(0, 0, 0, 0, 0, 0); expect_evt(0, 0, 1, 1, 16); step(20);
        apply_reset(1'b1);

        // ack on the last allowed clk is still honoured
        set_in(1, 1, 0, 0, 0, 0); expect_evt(1, 0, 0, 1, 1); step(1);
        set_in(0, 0, 0, 0, 0, 0); step(15);
        set_in(0, 0, 0, 1, 0, 1); expect_evt(0, 0, 0, 1, 1); step(1);
        set_in(0, 0, 0, 1, 0, 0); step(1);
        set_in(0, 0, 0, 0, 0, 0); step(1);

        // reset in the middle of ABORT kills the request
        set_in(1, 1, 0, 0, 0, 0); expect_evt(1, 0, 0, 2, 1); step(1);
        set_in(0, 0, 0, 0, 0, 0); step(3);
        apply_reset(1'b1);
        step(3);
        chk("post_rst_abort_req", 32'(bus.abort_req), 0);

        // 6: counter saturation via back-to-back abort/ack
        set_in(1, 1, 0, 0, 0, 0); expect_evt(1, 0, 0, 1, 1); step(1);
        for (int k = 2; k <= 260; k++) begin
            set_in(0, 0, 0, 0, 0, 1); expect_evt(0, 0, 0, (k - 1 > 255) ? 255 : k - 1, 1); step(1);
            set_in(1, 1, 0, 0, 0, 0); expect_evt(1, 0, 0, (k > 255) ? 255 : k, 1); step(1);
        end
        set_in(0, 0, 0, 0, 0, 1); expect_evt(0, 0, 0, 255, 1); step(1);
        set_in(0, 0, 0, 0, 0, 0); step(1);
        set_in(0, 1, 1, 0, 1, 0);
        #1 chk("bus_inhibit_idle_nostrobe", 32'(bus.bus_inhibit), 0);
        step(3);
        set_in(0, 0, 0, 0, 0, 0); step(3);
        chk("sat_count", 32'(bus.fault_count), 255);

        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
